// File: rtl/mult_accumulator.sv
// Block MAC stage: sums BLOCK_LEN signed products into a saturating accumulator
// and hands each block sum downstream over a valid/ready port.
module mult_accumulator #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ACC_WIDTH = 72,
    parameter int unsigned BLOCK_LEN = 4,
    localparam int unsigned CNT_W    = $clog2(BLOCK_LEN + 1),
    localparam int unsigned PROD_W   = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 prod_valid,
    input  logic [PROD_W-1:0]    prod,
    output logic                 prod_ready,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 sat,
    output logic [CNT_W-1:0]     cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;

    logic signed [ACC_WIDTH-1:0] prod_ext_c;
    logic signed [ACC_WIDTH:0]   sum_c;
    logic        [ACC_WIDTH-1:0] sum_sat_c;
    logic                        ovf_c;
    logic                        last_c;

    // One extra bit of headroom exposes overflow as a mismatch of the top two bits.
    always_comb begin
        prod_ext_c = ACC_WIDTH'($signed(prod));
        sum_c      = (ACC_WIDTH+1)'($signed(acc_out)) + (ACC_WIDTH+1)'(prod_ext_c);
        sum_sat_c  = sum_c[ACC_WIDTH-1:0];
        ovf_c      = 1'b0;
        if (sum_c[ACC_WIDTH] != sum_c[ACC_WIDTH-1]) begin
            ovf_c     = 1'b1;
            sum_sat_c = sum_c[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        last_c = (cnt == CNT_W'(BLOCK_LEN - 1));
    end

    // acc_out doubles as the running accumulator while in ACCUM.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= ACCUM;
            acc_out    <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            prod_ready <= 1'b1;
            acc_valid  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (prod_valid && prod_ready) begin
                        acc_out <= sum_sat_c;
                        sat     <= sat | ovf_c;
                        cnt     <= cnt + CNT_W'(1);
                        if (last_c) begin
                            state      <= HOLD;
                            prod_ready <= 1'b0;
                            acc_valid  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        state      <= ACCUM;
                        acc_out    <= '0;
                        cnt        <= '0;
                        sat        <= 1'b0;
                        prod_ready <= 1'b1;
                        acc_valid  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ACCUM;
                    prod_ready <= 1'b1;
                    acc_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench for mult_accumulator with a 64-bit accumulator so the
// saturation corners are reachable with 32-bit operand products.
module tb_mult_accumulator;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 64;
    localparam int unsigned BL    = 4;
    localparam int unsigned CW    = $clog2(BL + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          prod_valid;
    logic [PW-1:0] prod;
    logic          prod_ready;
    logic          acc_valid;
    logic          acc_ready;
    logic [AW-1:0] acc_out;
    logic          sat;
    logic [CW-1:0] cnt;

    mult_accumulator #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(AW),
        .BLOCK_LEN(BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .prod_valid(prod_valid),
        .prod      (prod),
        .prod_ready(prod_ready),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_out   (acc_out),
        .sat       (sat),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    typedef struct {
        logic [AW-1:0] sum;
        logic          sat;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: saturating block sum pushed on the accepting edge of the last product.
    logic signed [AW-1:0] m_acc;
    logic signed [AW:0]   m_sum;
    logic                 m_sat;
    int                   m_cnt;
    exp_t                 e;

    always @(negedge clk) begin
        if (rst || clr) begin
            m_acc = '0;
            m_sat = 1'b0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (acc_valid && acc_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_spurious", AW'(1), AW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum", acc_out, e.sum);
                    check("sb_sat", AW'(sat), AW'(e.sat));
                    n_pops++;
                end
            end
            if (prod_valid && prod_ready) begin
                m_sum = (AW+1)'(m_acc) + (AW+1)'($signed(prod));
                if (m_sum[AW] != m_sum[AW-1]) begin
                    m_sat = 1'b1;
                    m_acc = m_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
                end else begin
                    m_acc = m_sum[AW-1:0];
                end
                m_cnt++;
                if (m_cnt == BL) begin
                    e.sum = m_acc;
                    e.sat = m_sat;
                    exp_q.push_back(e);
                    m_acc = '0;
                    m_sat = 1'b0;
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer v and return just after the edge that accepts it.
    task automatic send(input longint v);
        bit ok = 1'b0;
        prod_valid = 1'b1;
        prod       = v;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (prod_ready) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        if (!ok) check("send_timeout", AW'(0), AW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        clr        = 1'b0;
        prod_valid = 1'b0;
        prod       = '0;
        acc_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_acc_valid",  AW'(acc_valid),  AW'(0));
        check("rst_acc_out",    acc_out,         AW'(0));
        check("rst_sat",        AW'(sat),        AW'(0));
        check("rst_cnt",        AW'(cnt),        AW'(0));
        check("rst_prod_ready", AW'(prod_ready), AW'(1));

        // Basic block
        send(-384); send(75); send(204); send(1500);
        prod_valid = 1'b0;
        check("t1_acc_valid",  AW'(acc_valid),  AW'(1));
        check("t1_acc_out",    acc_out,         AW'(1395));
        check("t1_sat",        AW'(sat),        AW'(0));
        check("t1_prod_ready", AW'(prod_ready), AW'(0));
        step();
        check("t1_pulse",      AW'(acc_valid),  AW'(0));
        check("t1_ready_back", AW'(prod_ready), AW'(1));
        check("t1_cnt_clear",  AW'(cnt),        AW'(0));

        // Backpressure with upstream still pushing
        acc_ready = 1'b0;
        send(0); send(12); send(-864); send(260);
        prod = PW'(77);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", AW'(acc_valid),  AW'(1));
            check("t2_hold_out",   acc_out,         AW'(-592));
            check("t2_hold_ready", AW'(prod_ready), AW'(0));
            step();
        end
        acc_ready = 1'b1;
        step();
        check("t2_handoff_valid", AW'(acc_valid),  AW'(0));
        check("t2_handoff_ready", AW'(prod_ready), AW'(1));
        check("t2_handoff_cnt",   AW'(cnt),        AW'(0));
        step();
        check("t2_next_accept",   AW'(cnt),        AW'(1));
        prod_valid = 1'b0;
        clr        = 1'b1;
        step();
        clr = 1'b0;

        // Positive saturation, then a clean block
        for (int i = 0; i < 4; i++) send(64'sh4000_0000_0000_0000);
        prod_valid = 1'b0;
        check("t3_sat_out", acc_out,  64'h7FFF_FFFF_FFFF_FFFF);
        check("t3_sat_flag", AW'(sat), AW'(1));
        step();
        for (int i = 0; i < 4; i++) send(1);
        prod_valid = 1'b0;
        check("t3_clean_out", acc_out,  AW'(4));
        check("t3_clean_sat", AW'(sat), AW'(0));
        step();

        // Negative saturation
        for (int i = 0; i < 4; i++) send(longint'(64'hBFFF_FFFF_8000_0000));
        prod_valid = 1'b0;
        check("t4_sat_out",  acc_out,  64'h8000_0000_0000_0000);
        check("t4_sat_flag", AW'(sat), AW'(1));
        step();

        // clr mid-block drops the partial sum and the offered product
        send(12); send(5);
        prod = PW'(999);
        clr  = 1'b1;
        step();
        clr        = 1'b0;
        prod_valid = 1'b0;
        check("t5_clr_cnt", AW'(cnt), AW'(0));
        check("t5_clr_acc", acc_out,  AW'(0));
        send(1); send(2); send(3); send(4);
        prod_valid = 1'b0;
        check("t5_out", acc_out, AW'(10));
        step();

        // Reset while holding a result
        acc_ready = 1'b0;
        send(-384); send(75); send(204); send(1500);
        prod_valid = 1'b0;
        check("t6_hold_valid", AW'(acc_valid), AW'(1));
        check("t6_hold_out",   acc_out,        AW'(1395));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_valid", AW'(acc_valid),  AW'(0));
        check("t6_rst_out",   acc_out,         AW'(0));
        check("t6_rst_cnt",   AW'(cnt),        AW'(0));
        check("t6_rst_ready", AW'(prod_ready), AW'(1));
        acc_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(1);
        prod_valid = 1'b0;
        check("t6_next_out", acc_out, AW'(4));
        repeat (3) step();

        check("sb_pops",  AW'(n_pops),        AW'(7));
        check("sb_empty", AW'(exp_q.size()),  AW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
